fp_mult_arbiter: RTL

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

---
 rtl/fp_mult_arbiter_if.sv | 30 +++
 rtl/fp_mult_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/fp_mult_arbiter_if.sv
// Requester/multiplier/response bundle for fp_mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface fp_mult_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 3
) ();
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic            mul_en;
    logic [31:0]     mul_out;
    logic [N-1:0]    rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic            idle;

    modport slave (
        input  req_valid, req_a, req_b, hold, mul_out,
        output req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_id, rsp_data, idle
    );

    modport master (
        output req_valid, req_a, req_b, hold, mul_out,
        input  req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_id, rsp_data, idle
    );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fp32 multiplier among N requesters;
// a LAT-deep {valid, id} pipe tags each product with its requester.
module fp_mult_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 9,
    parameter int IDW = 3
) (
    input logic              clk,
    input logic              rst,
    fp_mult_arbiter_if.slave bus
);
    localparam int unsigned NU = N;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptrNext;
    logic [IDW-1:0] gIdx;
    logic           gValid;
    logic [2*N-1:0] rotValid;
    int unsigned    sum;
    logic [31:0]    mulA;
    logic [31:0]    mulB;
    logic [LAT-1:0] vPipe;
    logic [IDW-1:0] idPipe [LAT];
    logic           rspHit;

    // Rotating the doubled request vector by ptr makes bit 0 the highest-priority slot.
    always_comb begin
        rotValid = {bus.req_valid, bus.req_valid} >> ptr;
        gValid   = 1'b0;
        sum      = 0;
        for (int unsigned j = 0; j < NU; j++) begin
            if (!gValid && rotValid[j]) begin
                gValid = 1'b1;
                sum    = 32'(ptr) + j;
            end
        end
        if (sum >= NU) begin
            sum = sum - NU;
        end
        gIdx    = IDW'(sum);
        gValid  = gValid & ~bus.hold & ~rst;
        ptrNext = (32'(gIdx) + 1 == NU) ? '0 : gIdx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            mulA  <= '0;
            mulB  <= '0;
            vPipe <= '0;
        end else begin
            vPipe[0] <= gValid;
            for (int unsigned i = 1; i < LAT; i++) begin
                vPipe[i] <= vPipe[i-1];
            end
            if (gValid) begin
                ptr  <= ptrNext;
                mulA <= bus.req_a[{gIdx, 5'd0} +: 32];
                mulB <= bus.req_b[{gIdx, 5'd0} +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        idPipe[0] <= gIdx;
        for (int unsigned i = 1; i < LAT; i++) begin
            idPipe[i] <= idPipe[i-1];
        end
    end

    assign rspHit        = vPipe[LAT-1] & ~rst;
    assign bus.req_ready = gValid ? (N'(1) << gIdx) : '0;
    assign bus.mul_a     = mulA;
    assign bus.mul_b     = mulB;
    assign bus.mul_en    = ~rst;
    assign bus.rsp_valid = rspHit ? (N'(1) << idPipe[LAT-1]) : '0;
    assign bus.rsp_id    = rspHit ? idPipe[LAT-1] : '0;
    assign bus.rsp_data  = bus.mul_out;
    assign bus.idle      = rst | (~|vPipe & ~gValid);
endmodule
